bist_scan_controller: RTL and testbench

BIST_SCAN_CONTROLLER -- requirements
Module: bist_scan_controller

---
 rtl/bist_scan_controller.sv | 121 ++++++++++++
 tb/tb_bist_scan_controller.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/bist_scan_controller.sv
// Logic BIST controller: LFSR pattern generation into a scan chain, MISR compaction
// of the scan-out stream, and signature compare against a golden value.
module bist_scan_controller #(
  parameter int unsigned CHAIN_LEN    = 8,
  parameter int unsigned NUM_PATTERNS = 16,
  parameter logic [7:0]  SEED         = 8'h01,
  parameter logic [7:0]  GOLDEN       = 8'h00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       SO,
  output logic       SE,
  output logic       SI,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [7:0] SIGNATURE
);

  localparam logic [7:0]  SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0]  LAST_BIT  = 8'(CHAIN_LEN - 1);
  localparam logic [15:0] PAT_TOTAL = 16'(NUM_PATTERNS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CAPTURE,
    S_UNLOAD,
    S_DONE
  } state_t;

  state_t      state, state_next;
  logic [7:0]  lfsr, misr, bit_cnt;
  logic [15:0] pat_cnt;
  logic [7:0]  lfsr_step, misr_step;
  logic [15:0] pat_inc;
  logic        last_bit;

  always_comb begin
    lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    misr_step = {misr[6:0], misr[7] ^ misr[5] ^ misr[4] ^ misr[3] ^ SO};
    pat_inc   = pat_cnt + 16'd1;
    last_bit  = (bit_cnt == LAST_BIT);
  end

  always_comb begin
    state_next = state;
    SE         = 1'b0;
    SI         = 1'b0;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    PASS       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (START) state_next = S_SHIFT;
      end
      S_SHIFT: begin
        SE   = 1'b1;
        SI   = lfsr[3];
        BUSY = 1'b1;
        if (last_bit) state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        BUSY = 1'b1;
        state_next = (pat_inc == PAT_TOTAL) ? S_UNLOAD : S_SHIFT;
      end
      S_UNLOAD: begin
        SE   = 1'b1;
        BUSY = 1'b1;
        if (last_bit) state_next = S_DONE;
      end
      S_DONE: begin
        DONE = 1'b1;
        PASS = (misr == GOLDEN);
        if (START) state_next = S_SHIFT;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign SIGNATURE = misr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      lfsr    <= SEED_EFF;
      misr    <= '0;
      bit_cnt <= '0;
      pat_cnt <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            lfsr    <= SEED_EFF;
            misr    <= '0;
            bit_cnt <= '0;
            pat_cnt <= '0;
          end
        end
        S_SHIFT: begin
          lfsr <= lfsr_step;
          // The first pattern's shift-out carries only reset/stale chain contents.
          if (pat_cnt != 16'd0) misr <= misr_step;
          bit_cnt <= last_bit ? 8'd0 : bit_cnt + 8'd1;
        end
        S_CAPTURE: begin
          pat_cnt <= pat_inc;
          bit_cnt <= '0;
        end
        S_UNLOAD: begin
          misr    <= misr_step;
          bit_cnt <= last_bit ? 8'd0 : bit_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_scan_controller.sv
// Bench for bist_scan_controller: cycle-by-cycle timing, pattern and signature
// checks against an arithmetic reference of the BIST run.
module tb_bist_scan_controller;

  localparam int unsigned CL      = 8;
  localparam int unsigned NP      = 4;
  localparam logic [7:0]  SEED_P  = 8'h01;
  localparam logic [7:0]  GOLD    = 8'h00;
  localparam int unsigned RUN_LEN = NP * (CL + 1) + CL;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       START = 1'b0;
  logic       SO = 1'b0;
  logic       SE, SI, BUSY, DONE, PASS;
  logic [7:0] SIGNATURE;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 CLK = ~CLK;

  bist_scan_controller #(
    .CHAIN_LEN   (CL),
    .NUM_PATTERNS(NP),
    .SEED        (SEED_P),
    .GOLDEN      (GOLD)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .SO       (SO),
    .SE       (SE),
    .SI       (SI),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .PASS     (PASS),
    .SIGNATURE(SIGNATURE)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_adv(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [7:0] misr_adv(input logic [7:0] v, input logic b);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3] ^ b};
  endfunction

  // so_mode: 0 = SO tied low, 1 = identity scan chain (SI delayed CL shifts), 2 = random
  task automatic run(input int unsigned so_mode, input int unsigned ign_a,
                     input int unsigned ign_b, input int unsigned abort_at,
                     output logic [7:0] sig);
    logic [7:0]    m_lfsr, m_misr;
    logic [CL-1:0] chain;
    logic [3:0]    si_ref;
    logic          so_b, e_se, e_si, in_shift, cap, unl;
    int unsigned   pat, pos, shift_no;
    m_lfsr   = SEED_P;
    m_misr   = '0;
    chain    = '0;
    si_ref   = 4'b1000;
    shift_no = 0;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int unsigned k = 1; k <= RUN_LEN; k++) begin
      pat      = (k - 1) / (CL + 1);
      pos      = (k - 1) % (CL + 1);
      in_shift = (pat < NP) && (pos < CL);
      cap      = (pat < NP) && (pos == CL);
      unl      = (pat >= NP);
      e_si     = in_shift ? m_lfsr[3] : 1'b0;
      e_se     = in_shift || unl;
      check_val($sformatf("busy_cyc%0d{BUSY,SE,SI,DONE,PASS}", k),
                {BUSY, SE, SI, DONE, PASS}, {1'b1, e_se, e_si, 2'b00});
      if (cap) check_val($sformatf("capture_cyc%0d_SE", k), SE, 1'b0);
      if (in_shift && shift_no < 4) begin
        check_val($sformatf("seed_si%0d", shift_no), SI, si_ref[shift_no[1:0]]);
      end
      case (so_mode)
        0:       so_b = 1'b0;
        1:       so_b = chain[CL-1];
        default: so_b = 1'($urandom_range(0, 1));
      endcase
      SO = so_b;
      if (e_se) chain = {chain[CL-2:0], e_si};
      if ((in_shift && pat > 0) || unl) m_misr = misr_adv(m_misr, so_b);
      if (in_shift) begin
        m_lfsr = lfsr_adv(m_lfsr);
        shift_no++;
      end
      START = (k == ign_a) || (k == ign_b);
      RST   = (k == abort_at);
      @(negedge CLK);
      START = 1'b0;
      if (k == abort_at) begin
        RST = 1'b0;
        check_val("abort_outputs", {BUSY, SE, SI, DONE, PASS, SIGNATURE}, '0);
        sig = m_misr;
        return;
      end
    end
    for (int unsigned h = 0; h < 3; h++) begin
      check_val($sformatf("done_hold%0d{BUSY,SE,SI,DONE}", h), {BUSY, SE, SI, DONE}, 4'b0001);
      check_val($sformatf("done_hold%0d_sig", h), SIGNATURE, m_misr);
      check_val($sformatf("done_hold%0d_pass", h), PASS, (m_misr == GOLD));
      SO = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    sig = m_misr;
  endtask

  logic [7:0] sig_zero, sig_delay, sig_tmp;

  initial begin
    RST   = 1'b1;
    START = 1'b1;
    repeat (2) @(negedge CLK);
    RST   = 1'b0;
    START = 1'b0;
    @(negedge CLK);
    check_val("reset_outputs", {BUSY, SE, SI, DONE, PASS, SIGNATURE}, '0);

    run(0, 0, 0, 0, sig_zero);
    check_val("zero_so_sig", SIGNATURE, 8'h00);
    check_val("zero_so_pass", PASS, 1'b1);

    run(1, 0, 0, 0, sig_delay);
    check_val("delay_pass", PASS, (sig_delay == GOLD));

    run(1, 3, 20, 0, sig_tmp);
    check_val("ignore_sig", SIGNATURE, sig_delay);

    for (int unsigned r = 0; r < 3; r++) run(2, 0, 0, 0, sig_tmp);

    run(1, 0, 0, 12, sig_tmp);
    for (int unsigned h = 0; h < 3; h++) begin
      check_val($sformatf("post_abort_idle%0d", h), {BUSY, SE, SI, DONE, PASS, SIGNATURE}, '0);
      @(negedge CLK);
    end
    run(1, 0, 0, 0, sig_tmp);
    check_val("restart_sig", SIGNATURE, sig_delay);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
